// File: rtl/mrv1_tw_sched_rr_if.sv
// Issue-scheduler bundle: per-warp status from the decode buffers and issue queues in,
// grant/backoff/stall-count out. master drives warp status, slave is the scheduler.
interface mrv1_tw_sched_rr_if #(
    parameter int NUM_TW_P = 8
);
    localparam int twid_width_lp = $clog2(NUM_TW_P);

    logic [NUM_TW_P-1:0]      tw_en_i;
    logic [NUM_TW_P-1:0]      tw_vld_i;
    logic [NUM_TW_P-1:0]      tw_iq_rdy_i;
    logic [NUM_TW_P-1:0]      tw_rs_conflict_i;
    logic                     exe_rdy_i;
    logic                     issue_vld_o;
    logic [twid_width_lp-1:0] issue_twid_o;
    logic [NUM_TW_P-1:0]      issue_gnt_o;
    logic [NUM_TW_P-1:0]      tw_backoff_o;
    logic [31:0]              stall_cnt_o;

    modport master (
        output tw_en_i, tw_vld_i, tw_iq_rdy_i, tw_rs_conflict_i, exe_rdy_i,
        input  issue_vld_o, issue_twid_o, issue_gnt_o, tw_backoff_o, stall_cnt_o
    );

    modport slave (
        input  tw_en_i, tw_vld_i, tw_iq_rdy_i, tw_rs_conflict_i, exe_rdy_i,
        output issue_vld_o, issue_twid_o, issue_gnt_o, tw_backoff_o, stall_cnt_o
    );
endinterface

// File: rtl/mrv1_tw_sched_rr.sv
// Round-robin warp issue scheduler with per-warp conflict backoff and a saturating stall counter.
// Define MRV1_TW_SCHED_STICKY_EN to let the last-issued warp keep the grant while it stays eligible.
module mrv1_tw_sched_rr #(
    parameter int NUM_TW_P         = 8,
    parameter int BACKOFF_CYCLES_P = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    mrv1_tw_sched_rr_if.slave sched_if
);
    localparam int twid_width_lp = $clog2(NUM_TW_P);

    logic [NUM_TW_P-1:0]      elig;
    logic [3:0]               bo_cnt_q [NUM_TW_P];
    logic [3:0]               bo_cnt_d [NUM_TW_P];
    logic [twid_width_lp-1:0] last_q, last_d;
    logic [twid_width_lp-1:0] winner;
    logic [twid_width_lp-1:0] cand;
    logic                     found;
    logic                     issue_vld;
    logic                     stall;
    logic [31:0]              stall_cnt_q, stall_cnt_d;

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    always_comb begin
        for (int i = 0; i < NUM_TW_P; i++) begin
            elig[i] = sched_if.tw_en_i[i] & sched_if.tw_vld_i[i] & sched_if.tw_iq_rdy_i[i] &
                      ~sched_if.tw_rs_conflict_i[i] & (bo_cnt_q[i] == 4'd0);
        end
    end

    // Search order last+1 .. last (wrapping); the final candidate is last_q itself.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        cand   = '0;
`ifdef MRV1_TW_SCHED_STICKY_EN
        if (elig[last_q]) begin
            winner = last_q;
            found  = 1'b1;
        end
`endif
        for (int k = 1; k <= NUM_TW_P; k++) begin
            cand = last_q + twid_width_lp'(k);
            if (!found && elig[cand]) begin
                winner = cand;
                found  = 1'b1;
            end
        end
    end

    assign issue_vld = sched_if.exe_rdy_i & found;
    assign stall     = sched_if.exe_rdy_i & (|(sched_if.tw_en_i & sched_if.tw_vld_i)) & ~found;

    assign sched_if.issue_vld_o  = issue_vld;
    assign sched_if.issue_twid_o = winner;
    assign sched_if.issue_gnt_o  = issue_vld ? (NUM_TW_P'(1) << winner) : '0;
    assign sched_if.stall_cnt_o  = stall_cnt_q;

    always_comb begin
        for (int i = 0; i < NUM_TW_P; i++) begin
            sched_if.tw_backoff_o[i] = (bo_cnt_q[i] != 4'd0);
        end
    end

    // A disabled warp drops any pending backoff; a conflict only reloads once the previous one expired.
    always_comb begin
        for (int i = 0; i < NUM_TW_P; i++) begin
            bo_cnt_d[i] = bo_cnt_q[i];
            if (!sched_if.tw_en_i[i]) begin
                bo_cnt_d[i] = 4'd0;
            end else if (sched_if.tw_vld_i[i] && sched_if.tw_rs_conflict_i[i] &&
                         (bo_cnt_q[i] == 4'd0)) begin
                bo_cnt_d[i] = 4'(BACKOFF_CYCLES_P);
            end else if (bo_cnt_q[i] != 4'd0) begin
                bo_cnt_d[i] = bo_cnt_q[i] - 4'd1;
            end
        end
    end

    assign last_d      = issue_vld ? winner : last_q;
    assign stall_cnt_d = stall ? sat_inc32(stall_cnt_q) : stall_cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_q      <= twid_width_lp'(NUM_TW_P - 1);
            stall_cnt_q <= 32'd0;
            for (int i = 0; i < NUM_TW_P; i++) begin
                bo_cnt_q[i] <= 4'd0;
            end
        end else begin
            last_q      <= last_d;
            stall_cnt_q <= stall_cnt_d;
            for (int i = 0; i < NUM_TW_P; i++) begin
                bo_cnt_q[i] <= bo_cnt_d[i];
            end
        end
    end
endmodule

// File: tb/tb_mrv1_tw_sched_rr.sv
// Scoreboard bench for mrv1_tw_sched_rr: reference model predicts each cycle's outputs,
// a monitor compares them; directed scenarios add targeted checks.
module tb_mrv1_tw_sched_rr;
    localparam int N  = 8;
    localparam int BO = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mrv1_tw_sched_rr_if #(.NUM_TW_P(N)) intf ();

    mrv1_tw_sched_rr #(.NUM_TW_P(N), .BACKOFF_CYCLES_P(BO)) dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .sched_if (intf)
    );

    typedef struct packed {
        logic        vld;
        logic [2:0]  twid;
        logic [7:0]  gnt;
        logic [7:0]  bo;
        logic [31:0] stall;
    } exp_t;

    exp_t        sb_q[$];
    int          n_vec = 0;
    int          n_err = 0;
    int          bo_m[N];
    int          last_m = N - 1;
    logic [31:0] stall_m = 32'd0;
    bit          model_ok = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Apply one cycle of stimulus, predict the outputs, then advance the model across the edge.
    task automatic drive(input bit r, input logic [7:0] en, input logic [7:0] vld,
                         input logic [7:0] rdy, input logic [7:0] cf, input bit ex);
        exp_t       e;
        int         win;
        int         j;
        bit         any;
        logic [7:0] el;
        @(negedge clk);
        rst                   = r;
        intf.tw_en_i          = en;
        intf.tw_vld_i         = vld;
        intf.tw_iq_rdy_i      = rdy;
        intf.tw_rs_conflict_i = cf;
        intf.exe_rdy_i        = ex;
        if (model_ok) begin
            el = '0;
            for (int i = 0; i < N; i++)
                el[i] = en[i] && vld[i] && rdy[i] && !cf[i] && (bo_m[i] == 0);
            win = 0;
            any = 1'b0;
`ifdef MRV1_TW_SCHED_STICKY_EN
            if (el[last_m]) begin
                win = last_m;
                any = 1'b1;
            end
`endif
            for (int k = 1; k <= N; k++) begin
                j = (last_m + k) % N;
                if (!any && el[j]) begin
                    win = j;
                    any = 1'b1;
                end
            end
            e.vld   = ex && any;
            e.twid  = 3'(win);
            e.gnt   = e.vld ? 8'(1 << win) : 8'h00;
            for (int i = 0; i < N; i++) e.bo[i] = (bo_m[i] != 0);
            e.stall = stall_m;
            sb_q.push_back(e);
            if (!r) begin
                if (e.vld) last_m = win;
                if (ex && (|(en & vld)) && !any && stall_m != 32'hFFFF_FFFF) stall_m = stall_m + 1;
                for (int i = 0; i < N; i++) begin
                    if (!en[i]) bo_m[i] = 0;
                    else if (vld[i] && cf[i] && bo_m[i] == 0) bo_m[i] = BO;
                    else if (bo_m[i] != 0) bo_m[i] = bo_m[i] - 1;
                end
            end
        end
        if (r) begin
            last_m  = N - 1;
            stall_m = 32'd0;
            for (int i = 0; i < N; i++) bo_m[i] = 0;
            model_ok = 1'b1;
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                n_vec++;
                if ({intf.issue_vld_o, intf.issue_twid_o, intf.issue_gnt_o,
                     intf.tw_backoff_o, intf.stall_cnt_o} !== e) begin
                    n_err++;
                    $display("FAIL scoreboard t=%0t: got vld=%b twid=%0d gnt=%h bo=%h stall=%h, expected vld=%b twid=%0d gnt=%h bo=%h stall=%h",
                             $time, intf.issue_vld_o, intf.issue_twid_o, intf.issue_gnt_o,
                             intf.tw_backoff_o, intf.stall_cnt_o,
                             e.vld, e.twid, e.gnt, e.bo, e.stall);
                end
            end
        end
    end

    initial begin
        logic [7:0] cf;
        bit         ex;
        intf.tw_en_i          = '0;
        intf.tw_vld_i         = '0;
        intf.tw_iq_rdy_i      = '0;
        intf.tw_rs_conflict_i = '0;
        intf.exe_rdy_i        = 1'b0;

        // all warps eligible: strict rotation from warp 0
        drive(1, 8'h00, 8'h00, 8'h00, 8'h00, 0);
        drive(1, 8'h00, 8'h00, 8'h00, 8'h00, 0);
        for (int i = 0; i < 16; i++) begin
            drive(0, 8'hFF, 8'hFF, 8'hFF, 8'h00, 1);
            #3;
            chk("rot_twid", 32'(intf.issue_twid_o), 32'(i % N));
            chk("rot_gnt", 32'(intf.issue_gnt_o), 32'(1 << (i % N)));
        end
        chk("rot_stall", intf.stall_cnt_o, 32'd0);

        // warps 2 and 5 with exe_rdy toggling
        drive(1, 8'h00, 8'h00, 8'h00, 8'h00, 0);
        for (int i = 0; i < 5; i++) begin
            ex = (i % 2 == 0);
            drive(0, 8'h24, 8'h24, 8'h24, 8'h00, ex);
            #3;
            chk("tog_gnt", 32'(intf.issue_gnt_o),
                (i == 1 || i == 3) ? 32'h00 : (i == 2 ? 32'h20 : 32'h04));
        end

        // warp 3 conflict at cycle 4
        drive(1, 8'h00, 8'h00, 8'h00, 8'h00, 0);
        for (int c = 0; c < 8; c++) begin
            cf = (c == 4) ? 8'h08 : 8'h00;
            drive(0, 8'h08, 8'h08, 8'h08, cf, 1);
            #3;
            chk("bo_flag3", 32'(intf.tw_backoff_o[3]), 32'((c == 5) || (c == 6)));
            chk("bo_gnt3", 32'(intf.issue_gnt_o[3]), 32'((c < 4) || (c == 7)));
            if (c == 7) chk("bo_stall", intf.stall_cnt_o, 32'd3);
        end

        // blocked issue queue, then saturation
        drive(1, 8'h00, 8'h00, 8'h00, 8'h00, 0);
        for (int c = 0; c < 10; c++) drive(0, 8'h02, 8'h02, 8'h00, 8'h00, 1);
        drive(0, 8'h00, 8'h00, 8'h00, 8'h00, 1);
        #3;
        chk("iq_stall10", intf.stall_cnt_o, 32'd10);
        chk("iq_nogrant", 32'(intf.issue_vld_o), 32'd0);
        force dut.stall_cnt_q = 32'hFFFF_FFFE;
        #1;
        release dut.stall_cnt_q;
        stall_m = 32'hFFFF_FFFE;
        for (int c = 0; c < 3; c++) drive(0, 8'h02, 8'h02, 8'h00, 8'h00, 1);
        drive(0, 8'h00, 8'h00, 8'h00, 8'h00, 1);
        #3;
        chk("sat_stall", intf.stall_cnt_o, 32'hFFFF_FFFF);

        // reset mid-stream after warp 6 issued
        drive(1, 8'h00, 8'h00, 8'h00, 8'h00, 0);
        drive(0, 8'hFF, 8'hFF, 8'h00, 8'h00, 1);
        for (int c = 0; c < 7; c++) begin
            cf = (c == 6) ? 8'h80 : 8'h00;
            drive(0, 8'hFF, 8'hFF, 8'hFF, cf, 1);
            #3;
            chk("mid_twid", 32'(intf.issue_twid_o), 32'(c));
        end
        chk("mid_stall_pre", intf.stall_cnt_o, 32'd1);
        drive(1, 8'hFF, 8'hFF, 8'hFF, 8'h00, 1);
        drive(0, 8'hFF, 8'hFF, 8'hFF, 8'h00, 1);
        #3;
        chk("rst_twid", 32'(intf.issue_twid_o), 32'd0);
        chk("rst_bo", 32'(intf.tw_backoff_o), 32'd0);
        chk("rst_stall", intf.stall_cnt_o, 32'd0);

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            drive(($urandom_range(0, 199) == 0),
                  8'($urandom) | 8'($urandom),
                  8'($urandom),
                  8'($urandom) | 8'($urandom),
                  8'($urandom) & 8'($urandom) & 8'($urandom),
                  ($urandom_range(0, 3) != 0));
        end

        @(negedge clk);
        #3;
        chk("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/mrv1_tw_sched_rr.md
# mrv1_tw_sched_rr

Round-robin thread-warp issue scheduler for the mrv1 multi-threaded core. Each cycle it picks one eligible warp from the per-warp decode buffers / issue queues and grants it issue to execute. It sits between the per-warp decode buffers / issue queues and the issue-stage source mux. It throttles warps that hit register-source conflicts with a per-warp backoff counter, and keeps a saturating stall counter for performance monitoring.

## Interface
- NUM_TW_P, 8, number of thread warps; ≥2, power of two.
- BACKOFF_CYCLES_P, 2, cycles a warp is masked after a source conflict; 1..15.
- twid_width_lp, $clog2(NUM_TW_P), warp id width (derived).
- clk_i  in  1  core clock.
- rst_i  in  1  synchronous, active-high reset.
- tw_en_i  in  NUM_TW_P  warp enable mask: the warp is launched and not halted.
- tw_vld_i  in  NUM_TW_P  the warp's decode buffer holds an instruction (not empty).
- tw_iq_rdy_i  in  NUM_TW_P  the warp's issue queue can accept an issue.
- tw_rs_conflict_i  in  NUM_TW_P  the warp's head instruction has an unresolved source dependency.
- exe_rdy_i  in  1  execute stage accepts an instruction this cycle.
- issue_vld_o  out  1  an instruction issues this cycle.
- issue_twid_o  out  twid_width_lp  id of the issuing warp; valid only when issue_vld_o=1.
- issue_gnt_o  out  NUM_TW_P  one-hot dequeue strobe to the granted warp's decode buffer and issue queue.
- tw_backoff_o  out  NUM_TW_P  the warp is currently in backoff.
- stall_cnt_o  out  32  saturating count of issue-stall cycles.

## Operation
- Eligibility per warp i: elig[i] = tw_en_i[i] & tw_vld_i[i] & tw_iq_rdy_i[i] & ~tw_rs_conflict_i[i] & (bo_cnt[i]==0).
- Backoff:
  - Each warp has a 4-bit bo_cnt.
  - If tw_en_i[i] & tw_vld_i[i] & tw_rs_conflict_i[i] and bo_cnt[i]==0, load BACKOFF_CYCLES_P.
  - Else if bo_cnt[i]!=0, decrement by 1.
  - tw_backoff_o[i] = (bo_cnt[i]!=0).
  - Clearing tw_en_i[i] clears bo_cnt[i] on the next edge.
- Arbitration:
  - Priority order starts at last_twid+1 and wraps modulo NUM_TW_P.
  - The first eligible warp wins.
  - last_twid is a register, reset to NUM_TW_P-1, so warp 0 has highest priority after reset.
- Issue:
  - issue_vld_o = exe_rdy_i & |elig.
  - issue_gnt_o = issue_vld_o ? onehot(winner) : 0.
  - issue_twid_o = winner; it is 0 when no warp is eligible.
- Pointer update: on issue_vld_o=1, last_twid ← winner. Otherwise last_twid holds.
- Stall counter:
  - A stall cycle is exe_rdy_i & |(tw_en_i & tw_vld_i) & ~|elig.
  - stall_cnt_o increments by 1 on each stall cycle and saturates at 0xFFFF_FFFF.
- exe_rdy_i=0: no grant. The pointer holds. Backoff counters still load and decrement.

## Timing
- Grant is combinational from inputs and registered state, with zero-cycle latency.
- The decode buffer dequeues on the same edge on which issue_gnt_o is high.
- Handshake: a warp issues only when issue_vld_o=1, which requires exe_rdy_i=1 in that cycle. There is no held request and no retry.
- Fairness: with all warps eligible continuously, each warp issues exactly once every NUM_TW_P cycles.
- Backoff timing: a conflict seen at edge k masks the warp for cycles k+1 .. k+BACKOFF_CYCLES_P. The warp is re-evaluated in cycle k+BACKOFF_CYCLES_P+1.
- A conflict and an eligible-on-other-warp condition in the same cycle are independent. The other warp is granted normally.
- Reset values:
  - last_twid=NUM_TW_P-1.
  - All bo_cnt=0.
  - stall_cnt_o=0.
  - Outputs are combinationally 0 while the inputs are 0.
- Reset mid-operation: all state is cleared on the edge. A grant shown in the reset cycle is ignored by the downstream blocks, which are also in reset.

## Configuration
- MRV1_TW_SCHED_STICKY_EN defined:
  - If warp last_twid is still eligible, it wins again, giving greedy-then-round-robin behaviour.
  - Otherwise the winner is chosen by normal round robin starting at last_twid+1.
- Undefined: strict round robin as described above. The last-issued warp has the lowest priority.

## Test plan
- Reset, all 8 warps eligible, exe_rdy_i=1 for 16 cycles -> issue_twid_o is 0,1,…,7,0,…,7. issue_gnt_o is one-hot each cycle. stall_cnt_o=0.
- Warps 2 and 5 eligible, exe_rdy_i toggling 1,0,1,0 -> grants are 2, none, 5, none, 2. The pointer holds during exe_rdy_i=0 cycles.
- Warp 3 only valid, tw_rs_conflict_i[3]=1 for one cycle at cycle 4, BACKOFF_CYCLES_P=2:
  - tw_backoff_o[3]=1 in cycles 5 and 6.
  - Warp 3 is not granted in cycles 4–6 and is granted in cycle 7.
  - stall_cnt_o=3.
- Warp 1 valid but tw_iq_rdy_i[1]=0 for 10 cycles with exe_rdy_i=1 -> no grants and stall_cnt_o=10. Force stall_cnt to 0xFFFF_FFFE, run 3 stall cycles -> stall_cnt_o=0xFFFF_FFFF.
- With MRV1_TW_SCHED_STICKY_EN and warps 0 and 4 eligible -> warp 0 is granted repeatedly. Drop tw_vld_i[0] -> warp 4 is granted next cycle and then repeats.
- Assert rst_i mid-stream after warp 6 issued -> in the next cycle with all warps eligible, warp 0 is granted. All tw_backoff_o=0 and stall_cnt_o=0.
